// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU responder: opcode encodings,
// FSM state encoding and the iteration count of the multi-cycle datapath.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_DIV  = 3'b110;
   localparam logic [2:0] OP_NONE = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Number of CALC cycles used by mul/div (one operand bit per cycle).
   localparam int unsigned ITER_COUNT = 32'd4;
   localparam logic [1:0]  ITER_LAST  = 2'(ITER_COUNT - 32'd1);

   // True for opcodes served by the iterative datapath.
   function automatic logic is_iter_op(input logic [2:0] sel);
      return (sel == OP_MUL) || (sel == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// ---------------------------------------------------------------------------
// alu_iter_unit
// Iterative 4x4 datapath: shift-add multiply (multiplier LSB first) and
// restoring divide (quotient MSB first), one bit per step.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load operands (a_i, b_i) and the operation (div_i)
//   div_i      : 1 = divide a_i / b_i, 0 = multiply a_i * b_i
//   step_i     : perform one iteration
//   done_o     : high during the final step; result_o is valid then
//   result_o   : product, or {4'b0, quotient}
// ---------------------------------------------------------------------------
module alu_iter_unit
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       div_i,
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       step_i,
   output logic       done_o,
   output logic [7:0] result_o
);

   // mul: acc = partial product, sh = shifted multiplicand, mq = multiplier
   // div: acc = remainder, sh[3:0] = divisor, mq = dividend shifting out
   //      while quotient bits shift in from the right
   logic       div_q, div_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] sh_q,  sh_d;
   logic [3:0] mq_q,  mq_d;
   logic [1:0] cnt_q, cnt_d;

   logic [7:0] addend_s;
   logic [4:0] trial_s;
   logic [4:0] diff_s;
   logic       fits_s;

   assign addend_s = mq_q[0] ? sh_q : 8'h00;
   assign trial_s  = {acc_q[3:0], mq_q[3]};
   assign diff_s   = trial_s - {1'b0, sh_q[3:0]};
   assign fits_s   = (trial_s >= {1'b0, sh_q[3:0]});

   // Next-state computation for load and iteration steps.
   always_comb begin
      div_d = div_q;
      acc_d = acc_q;
      sh_d  = sh_q;
      mq_d  = mq_q;
      cnt_d = cnt_q;
      if (start_i) begin
         div_d = div_i;
         acc_d = 8'h00;
         sh_d  = {4'h0, (div_i ? b_i : a_i)};
         mq_d  = div_i ? a_i : b_i;
         cnt_d = 2'd0;
      end else if (step_i) begin
         if (div_q) begin
            acc_d = {3'b000, (fits_s ? diff_s : trial_s)};
            mq_d  = {mq_q[2:0], fits_s};
         end else begin
            acc_d = acc_q + addend_s;
            sh_d  = {sh_q[6:0], 1'b0};
            mq_d  = {1'b0, mq_q[3:1]};
         end
         // Saturate: the counter never wraps into a fifth iteration.
         cnt_d = (cnt_q == ITER_LAST) ? cnt_q : (cnt_q + 2'd1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= 1'b0;
         acc_q <= 8'h00;
         sh_q  <= 8'h00;
         mq_q  <= 4'h0;
         cnt_q <= 2'd0;
      end else begin
         div_q <= div_d;
         acc_q <= acc_d;
         sh_q  <= sh_d;
         mq_q  <= mq_d;
         cnt_q <= cnt_d;
      end
   end

   // The final step's outcome is presented combinationally so the caller can
   // register it on the same edge that ends CALC.
   assign done_o   = step_i && (cnt_q == ITER_LAST);
   assign result_o = div_q ? {4'h0, mq_d} : acc_d;

endmodule

// File: rtl/alu_seq_responder.sv
// ---------------------------------------------------------------------------
// alu_seq_responder
// Command/response ALU on 4-bit unsigned operands. A command is captured in
// IDLE, evaluated in CALC (1 cycle, or 4 for mul/div) and held in DONE until
// the response handshake.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_a, cmd_b, cmd_sel        : operands and opcode
//   rsp_valid/rsp_ready          : response handshake
//   rsp_result                   : 8-bit result
//   rsp_carry, rsp_zero, rsp_divz: borrow, zero and divide-by-zero flags
//   busy                         : state is not IDLE
// ---------------------------------------------------------------------------
module alu_seq_responder
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [2:0] cmd_sel,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_carry,
   output logic       rsp_zero,
   output logic       rsp_divz,
   output logic       busy
);

   state_e     state_q;
   logic [3:0] a_q, b_q;
   logic [2:0] sel_q;
   logic       cmd_ready_q, rsp_valid_q, busy_q;
   logic [7:0] result_q;
   logic       carry_q, zero_q, divz_q;

   logic       iter_start_s, iter_step_s, iter_done_s;
   logic [7:0] iter_result_s;
   logic [8:0] sub_s;
   logic [7:0] sc_result_s;
   logic       sc_carry_s;

   assign iter_start_s = (state_q == ST_IDLE) && cmd_valid;
   assign iter_step_s  = (state_q == ST_CALC) && is_iter_op(sel_q);
   assign sub_s        = {5'b00000, a_q} - {5'b00000, b_q};

   alu_iter_unit u_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (iter_start_s),
      .div_i    (cmd_sel == OP_DIV),
      .a_i      (cmd_a),
      .b_i      (cmd_b),
      .step_i   (iter_step_s),
      .done_o   (iter_done_s),
      .result_o (iter_result_s)
   );

   // Single-cycle operations on the captured operands.
   always_comb begin
      sc_result_s = 8'h00;
      sc_carry_s  = 1'b0;
      case (sel_q)
         OP_ADD:  sc_result_s = {3'b000, ({1'b0, a_q} + {1'b0, b_q})};
         OP_SUB:  begin
            sc_result_s = sub_s[7:0];
            sc_carry_s  = sub_s[8];
         end
         OP_AND:  sc_result_s = {4'h0, (a_q & b_q)};
         OP_OR:   sc_result_s = {4'h0, (a_q | b_q)};
         OP_XOR:  sc_result_s = {4'h0, (a_q ^ b_q)};
         default: sc_result_s = 8'h00;
      endcase
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= 4'h0;
         b_q         <= 4'h0;
         sel_q       <= 3'b000;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= 8'h00;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         divz_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  a_q         <= cmd_a;
                  b_q         <= cmd_b;
                  sel_q       <= cmd_sel;
                  state_q     <= ST_CALC;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_CALC: begin
               if (is_iter_op(sel_q)) begin
                  if (iter_done_s) begin
                     state_q     <= ST_DONE;
                     rsp_valid_q <= 1'b1;
                     carry_q     <= 1'b0;
                     if ((sel_q == OP_DIV) && (b_q == 4'h0)) begin
                        result_q <= 8'hFF;
                        zero_q   <= 1'b0;
                        divz_q   <= 1'b1;
                     end else begin
                        result_q <= iter_result_s;
                        zero_q   <= (iter_result_s == 8'h00);
                        divz_q   <= 1'b0;
                     end
                  end
               end else begin
                  state_q     <= ST_DONE;
                  rsp_valid_q <= 1'b1;
                  result_q    <= sc_result_s;
                  carry_q     <= sc_carry_s;
                  zero_q      <= (sc_result_s == 8'h00);
                  divz_q      <= 1'b0;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign busy       = busy_q;
   assign rsp_result = result_q;
   assign rsp_carry  = carry_q;
   assign rsp_zero   = zero_q;
   assign rsp_divz   = divz_q;

endmodule

// File: doc/alu_seq_responder.md
ALU_SEQ_RESPONDER -- requirements
Module: alu_seq_responder

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are high on the same edge.
REQ-006 SHALL have ports cmd_a and cmd_b, input, 4 bits each: unsigned operands.
REQ-007 SHALL have port cmd_sel, input, 3 bits: opcode.
- 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 none.
REQ-008 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-009 SHALL have port rsp_ready, input, 1 bit: response consumed when rsp_valid and rsp_ready are high on the same edge.
REQ-010 SHALL have port rsp_result, output, 8 bits: operation result.
REQ-011 SHALL have ports rsp_carry, rsp_zero and rsp_divz, output, 1 bit each: carry/borrow, result-is-zero, and divide-by-zero flags.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
- cmd_ready = 1 only in IDLE.
- rsp_valid = 1 only in DONE.
REQ-014 SHALL, on command acceptance, register a, b and sel, leaving IDLE for CALC; the captured values are unaffected by later input changes.
REQ-015 SHALL complete add, sub, and, or, xor and none in exactly one CALC cycle (acceptance at edge N, rsp_valid high after edge N+1).
REQ-016 SHALL perform mul as shift-add over exactly 4 CALC cycles (rsp_valid high after edge N+4).
- one multiplier bit per cycle, LSB first.
REQ-017 SHALL perform div as restoring division over exactly 4 CALC cycles (rsp_valid high after edge N+4).
- one quotient bit per cycle, MSB first.
- rsp_result = {4'b0, quotient}; the remainder is discarded.
REQ-018 SHALL compute add as the zero-extended 5-bit sum, with rsp_carry = 0.
REQ-019 SHALL compute sub as the 9-bit two's-complement value {rsp_carry, rsp_result} = a - b mod 512 (borrow gives rsp_carry = 1).
REQ-020 SHALL compute and, or and xor as zero-extended 4-bit results, with rsp_carry = 0.
REQ-021 SHALL return the full 8-bit product for mul (max 225), with rsp_carry = 0.
REQ-022 SHALL, for div with b = 0, still take 4 cycles and return rsp_result = 8'hFF, rsp_divz = 1, rsp_zero = 0; otherwise rsp_divz = 0.
REQ-023 SHALL return rsp_result = 8'h00 for sel 111.
REQ-024 SHALL set rsp_zero = 1 iff rsp_result == 0 (excluding the div-by-zero case), registered alongside the result.
REQ-025 SHALL hold all rsp_* outputs stable in DONE until the rsp handshake; on that edge the FSM returns to IDLE.
REQ-026 SHALL not overlap commands and responses.
- A new command can be accepted no earlier than the cycle after the rsp handshake.
- Minimum 3-cycle throughput for single-cycle ops when rsp_ready is held high.
REQ-027 SHALL ignore cmd_valid outside IDLE and ignore rsp_ready outside DONE.
REQ-028 SHALL keep the iteration counter 2 bits wide, terminating CALC when the count reaches 3, with no wrap into a fifth iteration.

Reset
REQ-029 SHALL, on rst high at a clock edge, force state IDLE and clear internal registers, in any state including mid-CALC and mid-DONE.
- Outputs after reset: cmd_ready = 1; rsp_valid, busy, rsp_carry, rsp_zero, rsp_divz = 0; rsp_result = 8'h00.
REQ-030 SHALL give rst priority over a simultaneous cmd handshake; the command is dropped and no response is produced.

Structure
REQ-031 SHALL place the opcode constants (the 8 sel codes), the FSM state encoding and the iteration count constant (4) in shared package alu_pkg.
REQ-032 SHALL isolate the iterative mul/div datapath (accumulator, shifter, counter) in one sub-module alu_iter_unit, with a start/done interface; the FSM and single-cycle ops stay in the top module.

Verification
REQ-033 SHALL verify: add a=9, b=8, rsp_ready=1 -> rsp_result = 8'h11, carry = 0, zero = 0, rsp_valid exactly 1 cycle after acceptance.
REQ-034 SHALL verify: sub a=3, b=5 -> rsp_result = 8'hFE, carry = 1; sub a=7, b=7 -> 8'h00, carry = 0, zero = 1.
REQ-035 SHALL verify: mul a=15, b=15 -> rsp_result = 8'hE1 after 4 CALC cycles; div a=13, b=4 -> 8'h03 after 4 cycles.
REQ-036 SHALL verify: div a=6, b=0 -> rsp_result = 8'hFF, divz = 1, zero = 0.
REQ-037 SHALL verify: rsp_ready held low 10 cycles after an xor a=12, b=10 response -> result 8'h06 stable, cmd_ready = 0 throughout, a second cmd_valid is ignored.
REQ-038 SHALL verify: rst asserted at CALC cycle 2 of a mul -> next cycle IDLE, all outputs at reset values, no rsp_valid pulse follows.
